// File: rtl/chk_pkg.sv
// Shared types and default sizing for the frame data checker.
// Imported by the top and the reference generator.
package chk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_FRAME_LEN = 16;
  localparam int DEF_ERR_W     = 8;
  localparam int DEF_TIMEOUT   = 256;

endpackage

// File: rtl/chk_ref_gen.sv
// Expected-data generator: free-running incrementer that
// advances once per accepted beat and is only cleared by reset.
module chk_ref_gen
  import chk_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic [DATA_W-1:0] ref_val
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_val <= '0;
    end else if (adv) begin
      ref_val <= ref_val + 1'b1;
    end
  end

endmodule

// File: rtl/param_data_checker.sv
// Frame checker: compares incoming beats against an incrementing
// reference and reports errors, first-error index and timeouts.
module param_data_checker
  import chk_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ERR_W     = DEF_ERR_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  localparam int IDX_W    = $clog2(FRAME_LEN),
  localparam int TO_W     = $clog2(TIMEOUT + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_checking_done,
  output logic              o_valid_frame,
  output logic [ERR_W-1:0]  o_err_count,
  output logic [IDX_W-1:0]  o_first_err_idx,
  output logic              o_timeout,
  output logic              o_overrun,
  output logic              o_busy
);

  state_t state, state_nx;

  logic [IDX_W-1:0]  beat_cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  first_nx;
  logic [ERR_W-1:0]  err_base;
  logic [ERR_W-1:0]  err_nx;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] ref_val;
  logic              frame_on;
  logic              accept;
  logic              mismatch;
  logic              last;
  logic              idle_tick;
  logic              expire;

  chk_ref_gen #(
    .DATA_W (DATA_W)
  ) u_ref (
    .clk     (i_clk),
    .rst     (i_rst),
    .adv     (accept),
    .ref_val (ref_val)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A start pulse opens the frame in the same cycle, so a
  // coincident beat is treated as beat 0 with cleared history.
  always_comb begin
    frame_on  = i_start || (state == RECV);
    accept    = i_data_valid && frame_on;
    idx       = i_start ? '0 : beat_cnt;
    mismatch  = accept && (i_data != ref_val);
    last      = accept && (idx == IDX_W'(FRAME_LEN - 1));
    idle_tick = (state == RECV) && !i_start && !i_data_valid;
    expire    = idle_tick && (to_cnt == TO_W'(TIMEOUT - 1));
    err_base  = i_start ? '0 : o_err_count;
    err_nx    = err_base;
    first_nx  = i_start ? '0 : o_first_err_idx;
    if (mismatch) begin
      if (err_base != '1) begin
        err_nx = err_base + 1'b1;
      end
      if (err_base == '0) begin
        first_nx = idx;
      end
    end
    state_nx = state;
    unique case (state)
      IDLE: if (i_start) state_nx = RECV;
      RECV: if (!i_start && (last || expire)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_cnt        <= '0;
      to_cnt          <= '0;
      o_checking_done <= 1'b0;
      o_valid_frame   <= 1'b0;
      o_err_count     <= '0;
      o_first_err_idx <= '0;
      o_timeout       <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      o_checking_done <= last || expire;
      o_valid_frame   <= last && (err_nx == '0);
      o_err_count     <= err_nx;
      o_first_err_idx <= first_nx;
      if (accept) begin
        beat_cnt <= idx + 1'b1;
      end else if (i_start) begin
        beat_cnt <= '0;
      end
      if (i_start || accept) begin
        to_cnt <= '0;
      end else if (idle_tick) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (i_start) begin
        o_timeout <= 1'b0;
      end else if (expire) begin
        o_timeout <= 1'b1;
      end
      if (i_start) begin
        o_overrun <= 1'b0;
      end else if ((state == IDLE) && i_data_valid) begin
        o_overrun <= 1'b1;
      end
    end
  end

  assign o_busy = (state == RECV);

endmodule

// File: doc/param_data_checker.md
PARAM_DATA_CHECKER -- requirements
Module: param_data_checker

Interface
REQ-001 Parameter: DATA_W, 32, data bus width in bits (8..64).
REQ-002 Parameter: FRAME_LEN, 16, beats per frame (2..4096).
REQ-003 Parameter: ERR_W, 8, width of the error counter.
REQ-004 Parameter: TIMEOUT, 256, idle cycles allowed between beats inside a frame before the frame is aborted.
REQ-005 Derived: IDX_W = clog2(FRAME_LEN), TO_W = clog2(TIMEOUT+1).
REQ-006 One clock; reset is asynchronous and active-high; ports named i_clk and i_rst.
REQ-007 Port: i_clk  input  1  system clock.
REQ-008 Port: i_rst  input  1  async active-high reset.
REQ-009 Port: i_start  input  1  single-cycle pulse, arms checking of a new frame.
REQ-010 Port: i_data_valid  input  1  qualifies i_data.
REQ-011 Port: i_data  input  DATA_W  received data beat.
REQ-012 Port: o_checking_done  output  1  one-cycle pulse, frame check finished.
REQ-013 Port: o_valid_frame  output  1  one-cycle pulse coincident with done, frame correct.
REQ-014 Port: o_err_count  output  ERR_W  mismatching beats in last/current frame, saturating.
REQ-015 Port: o_first_err_idx  output  IDX_W  beat index of first mismatch.
REQ-016 Port: o_timeout  output  1  sticky, last frame aborted by timeout.
REQ-017 Port: o_overrun  output  1  sticky, valid beat received while not armed.
REQ-018 Port: o_busy  output  1  high while in RECV.

Function
REQ-019 FSM states IDLE, RECV; IDLE->RECV on i_start; RECV->IDLE on last beat or timeout; i_start in RECV restarts the frame (no done pulse for the abandoned frame).
REQ-020 Expected value exp (DATA_W bits) is compared combinationally with i_data in the same cycle; no input pipeline delay.
REQ-021 exp increments by 1 modulo 2^DATA_W on every beat accepted in RECV, match or not; exp is not cleared by i_start, so each frame continues from the previous stop value (0 after reset).
REQ-022 i_start clears beat counter, error count, first-error index, timeout counter, o_timeout, o_overrun.
REQ-023 i_start and i_data_valid in the same cycle: the beat is beat 0 of the new frame.
REQ-024 On a mismatching beat: o_err_count increments, saturating at 2^ERR_W-1; o_first_err_idx captures the beat index only if o_err_count was 0.
REQ-025 Beat FRAME_LEN-1 accepted -> next cycle o_checking_done=1 and o_valid_frame=1 iff final error count is 0.
REQ-026 Timeout counter increments each RECV cycle without i_data_valid, clears on any beat; at TIMEOUT -> IDLE, o_timeout=1, next cycle o_checking_done=1, o_valid_frame=0.
REQ-027 i_data_valid in IDLE (without i_start) sets o_overrun; data ignored, exp unchanged.
REQ-028 o_err_count, o_first_err_idx, o_timeout, o_overrun hold after done until next i_start.
REQ-029 All outputs registered; done/valid are single-cycle pulses.

Reset
REQ-030 On i_rst: state IDLE, exp=0, all counters 0, all outputs 0, o_first_err_idx=0; reset mid-frame discards the frame with no done pulse.

Structure
REQ-031 Shared package chk_pkg holds the state enumeration and default parameter constants.
REQ-032 Expected-data counter lives in one sub-module chk_ref_gen (load-free incrementer with advance enable).

Verification
REQ-033 Reset, start, 16 beats 0..15 back-to-back -> done+valid pulse the cycle after beat 15, err_count=0.
REQ-034 Second frame after first: beats 16..31 -> valid; sending 0..15 instead -> done, valid=0, err_count=16, first_err_idx=0.
REQ-035 Frame with beat 5 corrupted (0xDEADBEEF) -> err_count=1, first_err_idx=5, valid=0; next frame expects 16..31.
REQ-036 Start, 3 beats then 256 idle cycles -> o_timeout=1, done with valid=0, busy falls; valid beat afterwards without start -> o_overrun=1.
REQ-037 DATA_W=8, exp at 0xFE, 4-beat frame FE,FF,00,01 -> valid (wrap-around); ERR_W=2 with 5 errors -> err_count saturates at 3.
REQ-038 i_rst asserted at beat 7 -> no done pulse, all outputs 0, next frame expects exp=0; i_start mid-frame restarts counting with no done for the old frame.
